module_key_debouncer: RTL and testbench

Multi-channel input conditioner for the keypad path. Each of `WIDTH` asynchronous inputs passes through a `SYNC_STAGES`-deep flip-flop synchroniser and a per-channel stability counter. A channel's output level updates only after the synchronised input has held a new value for `DEBOUNCE_CYCLES` consecutive clocks. One-cycle rise and fall strobes accompany each accepted change. The block sits between the keypad row/column pins and the key-scan/encoder logic, all in the 10 MHz clock domain.

---
 rtl/module_key_debouncer.sv | 85 ++++++++
 tb/tb_module_key_debouncer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/module_key_debouncer.sv
// Multi-channel key debouncer: per-channel synchroniser plus stability counter.
// Outputs are registered levels with one-cycle rise/fall strobes on accepted changes.
module module_key_debouncer #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_W           =
        ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = D;
        for (int st = 1; st < SYNC_STAGES; st++) begin
            sync_d[st] = sync_q[st-1];
        end
    end

    // Counter runs only while the synchronised input disagrees with the output.
    always_comb begin
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != q_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    q_d[i]    = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!EN) begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_q[st] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            q_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_q[st] <= sync_d[st];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign Q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_module_key_debouncer.sv
// Directed bench for module_key_debouncer with WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Accepted changes appear 6 edges after the first edge that samples the new input.
module tb_module_key_debouncer;

    logic       clk = 1'b0;
    logic       EN;
    logic [1:0] D;
    logic [1:0] Q;
    logic [1:0] rise;
    logic [1:0] fall;

    int    checks = 0;
    int    errors = 0;
    int    stepn  = 0;
    string phase  = "init";

    module_key_debouncer #(
        .WIDTH          (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk (clk),
        .EN  (EN),
        .D   (D),
        .Q   (Q),
        .rise(rise),
        .fall(fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then check all outputs 1 time unit later.
    task automatic step(input logic [1:0] eq, input logic [1:0] er, input logic [1:0] ef);
        @(posedge clk);
        #1;
        stepn++;
        chk($sformatf("%s[%0d].Q", phase, stepn), Q, eq);
        chk($sformatf("%s[%0d].rise", phase, stepn), rise, er);
        chk($sformatf("%s[%0d].fall", phase, stepn), fall, ef);
    endtask

    task automatic set_phase(input string name);
        phase = name;
        stepn = 0;
    endtask

    logic bounce [9];

    initial begin
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        EN = 1'b0;
        D  = 2'b11;

        // Reset held for 3 edges with inputs high.
        set_phase("reset");
        repeat (3) step(2'b00, 2'b00, 2'b00);
        EN = 1'b1;
        repeat (5) step(2'b00, 2'b00, 2'b00);
        step(2'b11, 2'b11, 2'b00);
        step(2'b11, 2'b00, 2'b00);

        // Release both channels.
        set_phase("release_both");
        D = 2'b00;
        repeat (5) step(2'b11, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b11);
        step(2'b00, 2'b00, 2'b00);

        // Clean press and release on channel 0.
        set_phase("press0");
        D = 2'b01;
        repeat (5) step(2'b00, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        set_phase("release0");
        D = 2'b00;
        repeat (5) step(2'b01, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b00);

        // 3-clock pulse is rejected.
        set_phase("glitch3");
        D = 2'b01;
        repeat (3) step(2'b00, 2'b00, 2'b00);
        D = 2'b00;
        repeat (6) step(2'b00, 2'b00, 2'b00);

        // 4-clock pulse is accepted and Q is high for exactly 4 cycles.
        set_phase("pulse4");
        D = 2'b01;
        repeat (4) step(2'b00, 2'b00, 2'b00);
        D = 2'b00;
        step(2'b00, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        repeat (3) step(2'b01, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b00);

        // Bounce: only the final run of four 1s is accepted.
        set_phase("bounce");
        for (int i = 0; i < 9; i++) begin
            D = {1'b0, bounce[i]};
            step(2'b00, 2'b00, 2'b00);
        end
        step(2'b00, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        set_phase("bounce_release");
        D = 2'b00;
        repeat (5) step(2'b01, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b00);

        // Reset after the counter has advanced twice; latency restarts in full.
        set_phase("reset_mid");
        D = 2'b01;
        repeat (4) step(2'b00, 2'b00, 2'b00);
        EN = 1'b0;
        step(2'b00, 2'b00, 2'b00);
        EN = 1'b1;
        repeat (5) step(2'b00, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b00);

        // Simultaneous opposite changes give simultaneous strobes.
        set_phase("simul");
        D = 2'b10;
        repeat (5) step(2'b01, 2'b00, 2'b00);
        step(2'b10, 2'b10, 2'b01);
        step(2'b10, 2'b00, 2'b00);

        // Channel 1 changes one clock after channel 0: strobes one cycle apart.
        set_phase("staggered");
        D = 2'b11;
        step(2'b10, 2'b00, 2'b00);
        D = 2'b01;
        repeat (4) step(2'b10, 2'b00, 2'b00);
        step(2'b11, 2'b01, 2'b00);
        step(2'b01, 2'b00, 2'b10);
        step(2'b01, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
